dma_tile_scheduler: RTL and testbench
=====================================

Name: dma_tile_scheduler

Overview:
- Sequences tiled jobs through the DMA engine, the 2-bank on-chip buffer and the multi-lane MAC compute path.
- Accepts one job descriptor: source base, tile size and tile count.
- Issues one DMA transfer per tile into alternating (ping-pong) banks and hands each filled bank to compute.
- Overlaps the next tile's load with the current tile's compute.

Parameters:
- ADDR_WIDTH, 32, address and size width.
- CNT_WIDTH, 16, tile counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- job_valid_i  in  1  job descriptor valid.
- job_ready_o  out  1  scheduler idle, can accept a job.
- job_src_addr_i  in  ADDR_WIDTH  base address of tile 0.
- job_tile_bytes_i  in  ADDR_WIDTH  bytes per tile; also the stride between tiles.
- job_num_tiles_i  in  CNT_WIDTH  number of tiles.
- dma_cfg_valid_o  out  1  one-cycle configuration strobe.
- dma_start_o  out  1  one-cycle start strobe, coincident with dma_cfg_valid_o.
- dma_src_addr_o  out  ADDR_WIDTH  tile source address.
- dma_size_o  out  ADDR_WIDTH  tile size.
- dma_bank_o  out  1  buffer bank the DMA writes.
- dma_ready_i  in  1  DMA engine idle.
- dma_done_i  in  1  one-cycle transfer-complete pulse.
- cmp_valid_o  out  1  compute request.
- cmp_bank_o  out  1  bank the compute path reads.
- cmp_ready_i  in  1  compute accepts the request.
- cmp_done_i  in  1  one-cycle compute-complete pulse.
- busy_o  out  1  job in progress.
- job_done_o  out  1  one-cycle job-complete pulse.
- tiles_done_o  out  CNT_WIDTH  tiles computed in the current or last job.

Behaviour:
Clocking and reset:
- Single clock domain on clk_i.
- rst_ni is asynchronous and active-low. Reset may assert mid-job; it aborts the job with no further strobes.
- After reset all outputs are 0, except job_ready_o = 1.
- After reset all internal registers are 0: bank-full flags, write/read bank pointers, and the issued/loaded/computed counters.

Job acceptance:
- A job is accepted when job_valid_i && job_ready_o. The descriptor is latched.
- On acceptance: next_addr = job_src_addr_i, all counters cleared, both full flags cleared, both bank pointers set to 0.
- busy_o = 1 and job_ready_o = 0 from the next cycle.
- job_num_tiles_i == 0: job_done_o pulses the cycle after acceptance, busy_o stays 0, no DMA or compute activity.
- tiles_done_o is cleared on acceptance and holds its final value after job_done_o.

Load FSM (L_IDLE, L_ISSUE, L_WAIT):
- L_IDLE goes to L_ISSUE while busy and issued < num_tiles.
- In L_ISSUE, when !full[wr_bank] && dma_ready_i:
  - dma_cfg_valid_o and dma_start_o pulse for 1 cycle.
  - dma_src_addr_o = next_addr, dma_size_o = tile_bytes, dma_bank_o = wr_bank.
  - Then: issued++, next_addr += tile_bytes (wraps modulo 2^ADDR_WIDTH), go to L_WAIT.
- dma_src_addr_o, dma_size_o and dma_bank_o hold stable from the strobe until dma_done_i.
- L_WAIT on dma_done_i: set full[wr_bank], toggle wr_bank, go to L_IDLE.
- dma_done_i outside L_WAIT is ignored.
- Earliest first strobe is the cycle after acceptance. Minimum gap between strobes is 2 cycles after dma_done_i.

Compute FSM (C_IDLE, C_REQ, C_WAIT):
- C_IDLE goes to C_REQ when full[rd_bank].
- C_REQ: cmp_valid_o = 1 and cmp_bank_o = rd_bank, held until cmp_ready_i. cmp_valid_o must not drop without handshake.
- After the handshake, go to C_WAIT.
- C_WAIT on cmp_done_i: clear full[rd_bank], toggle rd_bank, computed++.
  - If computed+1 == num_tiles: job_done_o pulses that next cycle, busy_o falls, job_ready_o rises.
  - Otherwise go to C_IDLE.
- cmp_done_i outside C_WAIT is ignored.

Concurrency and boundaries:
- Set and clear of full flags in the same cycle target different banks. Loading requires the target bank empty, so they can never collide.
- Both banks full: the load FSM stalls in L_ISSUE until compute frees wr_bank.
- A freed bank is visible to L_ISSUE the cycle after the clear.
- job_valid_i while busy is not accepted and stays pending.
- num_tiles = 2^CNT_WIDTH-1 must complete without counter overflow.

Test Plan:
- Reset, then no stimulus -> job_ready_o=1; all other outputs 0; no strobes for 20 cycles.
- Job (src=0x1000, bytes=0x40, tiles=3); DMA done 4 cycles after each start; cmp_ready immediate; cmp_done 10 cycles after handshake:
  - strobes at addresses 0x1000, 0x1040, 0x1080 on banks 0, 1, 0;
  - second load overlaps first compute;
  - job_done_o single pulse; tiles_done_o=3.
- Compute slow (done 50 cycles after handshake), DMA fast -> third dma_start_o is withheld until the cmp_done_i of tile 0; never more than 2 banks full.
- cmp_ready_i held low 7 cycles -> cmp_valid_o stays high with constant cmp_bank_o; exactly one handshake per tile.
- tiles=0 -> job_done_o pulses the cycle after acceptance; no DMA or compute strobe; tiles_done_o=0.
- Reset asserted mid-job during L_WAIT, then a new job (src=0x2000, tiles=1) -> outputs return to reset values immediately; new job starts at 0x2000 on bank 0 and completes normally.

Source files
------------

// File: rtl/dma_tile_scheduler.sv
// dma_tile_scheduler: ping-pong tile sequencer between DMA and MAC compute.
// A load FSM and a compute FSM share two bank-full flags so loads overlap compute.
module dma_tile_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [ADDR_WIDTH-1:0] job_src_addr_i,
  input  logic [ADDR_WIDTH-1:0] job_tile_bytes_i,
  input  logic [CNT_WIDTH-1:0]  job_num_tiles_i,
  output logic                  dma_cfg_valid_o,
  output logic                  dma_start_o,
  output logic [ADDR_WIDTH-1:0] dma_src_addr_o,
  output logic [ADDR_WIDTH-1:0] dma_size_o,
  output logic                  dma_bank_o,
  input  logic                  dma_ready_i,
  input  logic                  dma_done_i,
  output logic                  cmp_valid_o,
  output logic                  cmp_bank_o,
  input  logic                  cmp_ready_i,
  input  logic                  cmp_done_i,
  output logic                  busy_o,
  output logic                  job_done_o,
  output logic [CNT_WIDTH-1:0]  tiles_done_o
);

  typedef enum logic [1:0] {
    L_IDLE,
    L_ISSUE,
    L_WAIT
  } lstate_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_REQ,
    C_WAIT
  } cstate_e;

  lstate_e lstate_q, lstate_d;
  cstate_e cstate_q, cstate_d;

  logic                  busy_q, busy_d;
  logic                  job_done_q, job_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] bytes_q, bytes_d;
  logic [ADDR_WIDTH-1:0] dma_addr_q, dma_addr_d;
  logic [ADDR_WIDTH-1:0] dma_size_q, dma_size_d;
  logic                  dma_bank_q, dma_bank_d;
  logic [CNT_WIDTH-1:0]  ntiles_q, ntiles_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [CNT_WIDTH-1:0]  computed_q, computed_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;

  logic accept;
  logic more_tiles;
  logic dma_fire;
  logic ld_done;
  logic cp_done;
  logic last_tile;

  assign accept     = job_valid_i && !busy_q;
  assign more_tiles = busy_q && (issued_q < ntiles_q);
  assign dma_fire   = (lstate_q == L_ISSUE)
                    && !full_q[wr_bank_q]
                    && dma_ready_i;
  assign ld_done    = (lstate_q == L_WAIT) && dma_done_i;
  assign cp_done    = (cstate_q == C_WAIT) && cmp_done_i;
  // Widened compare so the maximum tile count cannot wrap.
  assign last_tile  = (({1'b0, computed_q} + 1'b1)
                    == {1'b0, ntiles_q});

  // Load FSM next state: a new job jumps straight to issue.
  always_comb begin
    lstate_d = lstate_q;
    unique case (lstate_q)
      L_IDLE:  if (more_tiles) lstate_d = L_ISSUE;
      L_ISSUE: if (dma_fire) lstate_d = L_WAIT;
      L_WAIT:  if (dma_done_i) lstate_d = L_IDLE;
      default: lstate_d = L_IDLE;
    endcase
    if (accept) begin
      lstate_d = (job_num_tiles_i != '0) ? L_ISSUE : L_IDLE;
    end
  end

  // Compute FSM next state: request a full bank, hold until accepted.
  always_comb begin
    cstate_d = cstate_q;
    unique case (cstate_q)
      C_IDLE:  if (full_q[rd_bank_q]) cstate_d = C_REQ;
      C_REQ:   if (cmp_ready_i) cstate_d = C_WAIT;
      C_WAIT:  if (cmp_done_i) cstate_d = C_IDLE;
      default: cstate_d = C_IDLE;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lstate_q <= L_IDLE;
      cstate_q <= C_IDLE;
    end else begin
      lstate_q <= lstate_d;
      cstate_q <= cstate_d;
    end
  end

  // Job, bank and counter bookkeeping; acceptance overrides everything.
  always_comb begin
    busy_d     = busy_q;
    job_done_d = 1'b0;
    addr_d     = addr_q;
    bytes_d    = bytes_q;
    dma_addr_d = dma_addr_q;
    dma_size_d = dma_size_q;
    dma_bank_d = dma_bank_q;
    ntiles_d   = ntiles_q;
    issued_d   = issued_q;
    computed_d = computed_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    unique case (1'b1)
      accept: begin
        busy_d     = (job_num_tiles_i != '0);
        job_done_d = (job_num_tiles_i == '0);
        addr_d     = job_src_addr_i;
        bytes_d    = job_tile_bytes_i;
        ntiles_d   = job_num_tiles_i;
        issued_d   = '0;
        computed_d = '0;
        full_d     = '0;
        wr_bank_d  = 1'b0;
        rd_bank_d  = 1'b0;
      end
      default: begin
        if (dma_fire) begin
          dma_addr_d = addr_q;
          dma_size_d = bytes_q;
          dma_bank_d = wr_bank_q;
          issued_d   = issued_q + 1'b1;
          addr_d     = addr_q + bytes_q;
        end
        if (ld_done) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
        if (cp_done) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          computed_d        = computed_q + 1'b1;
          if (last_tile) begin
            busy_d     = 1'b0;
            job_done_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      addr_q     <= '0;
      bytes_q    <= '0;
      dma_addr_q <= '0;
      dma_size_q <= '0;
      dma_bank_q <= 1'b0;
      ntiles_q   <= '0;
      issued_q   <= '0;
      computed_q <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      job_done_q <= job_done_d;
      addr_q     <= addr_d;
      bytes_q    <= bytes_d;
      dma_addr_q <= dma_addr_d;
      dma_size_q <= dma_size_d;
      dma_bank_q <= dma_bank_d;
      ntiles_q   <= ntiles_d;
      issued_q   <= issued_d;
      computed_q <= computed_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // Descriptor is live on the strobe cycle, then held from the latch.
  assign dma_cfg_valid_o = dma_fire;
  assign dma_start_o     = dma_fire;
  assign dma_src_addr_o  = dma_fire ? addr_q : dma_addr_q;
  assign dma_size_o      = dma_fire ? bytes_q : dma_size_q;
  assign dma_bank_o      = dma_fire ? wr_bank_q : dma_bank_q;

  assign cmp_valid_o  = (cstate_q == C_REQ);
  assign cmp_bank_o   = rd_bank_q;
  assign busy_o       = busy_q;
  assign job_ready_o  = !busy_q;
  assign job_done_o   = job_done_q;
  assign tiles_done_o = computed_q;

endmodule

// File: tb/tb_dma_tile_scheduler.sv
// tb_dma_tile_scheduler: reactive DMA/compute responders plus
// table-driven, hand-written and random jobs checked against a tile model.
module tb_dma_tile_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [31:0] job_src_addr_i = '0;
  logic [31:0] job_tile_bytes_i = '0;
  logic [15:0] job_num_tiles_i = '0;
  logic        dma_cfg_valid_o;
  logic        dma_start_o;
  logic [31:0] dma_src_addr_o;
  logic [31:0] dma_size_o;
  logic        dma_bank_o;
  logic        dma_ready_i = 1'b1;
  logic        dma_done_i = 1'b0;
  logic        cmp_valid_o;
  logic        cmp_bank_o;
  logic        cmp_ready_i = 1'b0;
  logic        cmp_done_i = 1'b0;
  logic        busy_o;
  logic        job_done_o;
  logic [15:0] tiles_done_o;

  dma_tile_scheduler #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .job_valid_i      (job_valid_i),
    .job_ready_o      (job_ready_o),
    .job_src_addr_i   (job_src_addr_i),
    .job_tile_bytes_i (job_tile_bytes_i),
    .job_num_tiles_i  (job_num_tiles_i),
    .dma_cfg_valid_o  (dma_cfg_valid_o),
    .dma_start_o      (dma_start_o),
    .dma_src_addr_o   (dma_src_addr_o),
    .dma_size_o       (dma_size_o),
    .dma_bank_o       (dma_bank_o),
    .dma_ready_i      (dma_ready_i),
    .dma_done_i       (dma_done_i),
    .cmp_valid_o      (cmp_valid_o),
    .cmp_bank_o       (cmp_bank_o),
    .cmp_ready_i      (cmp_ready_i),
    .cmp_done_i       (cmp_done_i),
    .busy_o           (busy_o),
    .job_done_o       (job_done_o),
    .tiles_done_o     (tiles_done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  int dma_lat = 1;
  int rdy_lat = 0;
  int cmp_lat = 1;
  bit rand_rdy = 1'b0;
  int dma_done_at = -1;
  int cmp_done_at = -1;
  int wait_cnt = 0;

  logic [31:0] st_addr[$];
  logic [31:0] st_size[$];
  bit          st_bank[$];
  int          st_cyc[$];
  int          dd_cyc[$];
  bit          hs_bank[$];
  int          cd_cyc[$];
  int          ndone = 0;
  int          done_cyc = -1;
  logic [15:0] done_tiles = '0;
  bit          any_busy = 1'b0;

  bit          holding = 1'b0;
  logic [31:0] h_addr, h_size;
  bit          h_bank;
  bit          pend = 1'b0;
  bit          pend_bank;

  task automatic chk_eq(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Responders: drive inputs just after posedge, observe at negedge.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      dma_done_i  = (cyc == dma_done_at);
      cmp_done_i  = (cyc == cmp_done_at);
      cmp_ready_i = (wait_cnt >= rdy_lat);
      dma_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk_i);
      if (!rst_ni) begin
        holding = 1'b0;
        pend    = 1'b0;
      end else begin
        if (dma_start_o) begin
          chk_eq("cfg_with_start", 64'(dma_cfg_valid_o), 64'd1);
          chk_eq("banks_in_use",
                 64'((st_addr.size() - cd_cyc.size()) < 2), 64'd1);
          st_addr.push_back(dma_src_addr_o);
          st_size.push_back(dma_size_o);
          st_bank.push_back(dma_bank_o);
          st_cyc.push_back(cyc);
          dma_done_at = cyc + dma_lat;
          holding = 1'b1;
          h_addr  = dma_src_addr_o;
          h_size  = dma_size_o;
          h_bank  = dma_bank_o;
        end else if (holding) begin
          chk_eq("dma_addr_hold", 64'(dma_src_addr_o), 64'(h_addr));
          chk_eq("dma_size_hold", 64'(dma_size_o), 64'(h_size));
          chk_eq("dma_bank_hold", 64'(dma_bank_o), 64'(h_bank));
        end
        if (holding && cyc == dma_done_at) begin
          holding = 1'b0;
          dd_cyc.push_back(cyc);
        end
        if (pend) begin
          chk_eq("cmp_valid_held", 64'(cmp_valid_o), 64'd1);
          chk_eq("cmp_bank_held", 64'(cmp_bank_o), 64'(pend_bank));
        end
        if (cmp_valid_o && cmp_ready_i) begin
          hs_bank.push_back(cmp_bank_o);
          cmp_done_at = cyc + cmp_lat;
          wait_cnt = 0;
          pend = 1'b0;
        end else if (cmp_valid_o) begin
          wait_cnt++;
          pend = 1'b1;
          pend_bank = cmp_bank_o;
        end else begin
          pend = 1'b0;
        end
        if (cyc == cmp_done_at) cd_cyc.push_back(cyc);
        if (job_done_o) begin
          ndone++;
          done_cyc = cyc;
          done_tiles = tiles_done_o;
        end
        if (busy_o) any_busy = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    st_addr.delete();
    st_size.delete();
    st_bank.delete();
    st_cyc.delete();
    dd_cyc.delete();
    hs_bank.delete();
    cd_cyc.delete();
    ndone = 0;
    done_cyc = -1;
    any_busy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_strobes"},
           64'({dma_cfg_valid_o, dma_start_o, dma_bank_o, cmp_valid_o,
                cmp_bank_o, busy_o, job_done_o}), 64'd0);
    chk_eq({tag, "_addr"}, 64'(dma_src_addr_o), 64'd0);
    chk_eq({tag, "_size"}, 64'(dma_size_o), 64'd0);
    chk_eq({tag, "_tiles"}, 64'(tiles_done_o), 64'd0);
    chk_eq({tag, "_ready"}, 64'(job_ready_o), 64'd1);
  endtask

  task automatic start_job(input logic [31:0] src, input logic [31:0] bytes,
                           input int n, input int dl, input int rl,
                           input int cl, output int acc);
    dma_lat = dl;
    rdy_lat = rl;
    cmp_lat = cl;
    clear_logs();
    @(posedge clk_i); #2;
    job_valid_i = 1'b1;
    job_src_addr_i = src;
    job_tile_bytes_i = bytes;
    job_num_tiles_i = n[15:0];
    acc = -1;
    for (int t = 0; t < 50 && acc < 0; t++) begin
      @(negedge clk_i); #2;
      if (job_ready_o) acc = cyc;
    end
    @(posedge clk_i); #2;
    job_valid_i = 1'b0;
    chk_eq("job_accepted", 64'(acc >= 0), 64'd1);
  endtask

  task automatic wait_job(input int n);
    for (int t = 0; t < 200 + n * 120 && ndone == 0; t++) begin
      @(negedge clk_i); #2;
    end
    chk_eq("job_done_seen", 64'(ndone > 0), 64'd1);
    repeat (5) @(negedge clk_i);
    #2;
  endtask

  // Tile model: tile i reads src + i*bytes into bank i%2.
  task automatic check_job(input logic [31:0] src, input logic [31:0] bytes,
                           input int n, input int acc, input bit timing,
                           input int exp_tiles, input logic [31:0] exp_last,
                           input bit exp_bank);
    logic [31:0] ea;
    int et;
    chk_eq("done_pulses", 64'(ndone), 64'd1);
    chk_eq("tiles_done", 64'(done_tiles), 64'(exp_tiles));
    chk_eq("tiles_done_hold", 64'(tiles_done_o), 64'(exp_tiles));
    chk_eq("n_strobes", 64'(st_addr.size()), 64'(n));
    chk_eq("n_handshakes", 64'(hs_bank.size()), 64'(n));
    chk_eq("was_busy", 64'(any_busy), 64'd1);
    chk_eq("idle_after", 64'({busy_o, job_ready_o}), 64'b01);
    if (n > 0 && st_addr.size() == n && hs_bank.size() == n &&
        cd_cyc.size() == n && dd_cyc.size() == n) begin
      for (int i = 0; i < n; i++) begin
        ea = src + 32'(i) * bytes;
        chk_eq("tile_addr", 64'(st_addr[i]), 64'(ea));
        chk_eq("tile_size", 64'(st_size[i]), 64'(bytes));
        chk_eq("tile_bank", 64'(st_bank[i]), 64'(i % 2));
        chk_eq("cmp_bank", 64'(hs_bank[i]), 64'(i % 2));
        if (timing) begin
          if (i == 0) et = acc + 1;
          else et = dd_cyc[i-1] + 2;
          if (i >= 2 && cd_cyc[i-2] + 1 > et) et = cd_cyc[i-2] + 1;
          chk_eq("strobe_cycle", 64'(st_cyc[i]), 64'(et));
        end
      end
      chk_eq("last_addr", 64'(st_addr[n-1]), 64'(exp_last));
      chk_eq("last_bank", 64'(st_bank[n-1]), 64'(exp_bank));
      chk_eq("done_cycle", 64'(done_cyc), 64'(cd_cyc[n-1] + 1));
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] bytes;
    int          n;
    int          dl;
    int          rl;
    int          cl;
    int          exp_tiles;
    logic [31:0] exp_last;
    bit          exp_bank;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int acc;
    int n;
    logic [31:0] src, bytes;

    tbl[0] = '{32'h1000, 32'h40, 3, 4, 0, 10, 3, 32'h1080, 1'b0};
    tbl[1] = '{32'h0, 32'h100, 4, 1, 0, 50, 4, 32'h300, 1'b1};
    tbl[2] = '{32'h500, 32'h20, 2, 2, 7, 3, 2, 32'h520, 1'b1};
    tbl[3] = '{32'hFFFF_FFC0, 32'h40, 3, 3, 1, 5, 3, 32'h40, 1'b0};
    tbl[4] = '{32'h7000, 32'h10, 1, 2, 0, 2, 1, 32'h7000, 1'b0};
    tbl[5] = '{32'h100, 32'h8, 6, 5, 2, 1, 6, 32'h128, 1'b1};

    // Reset and quiet period.
    #1 rst_ni = 1'b0;
    #1 check_reset_outputs("in_reset");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk_i);
    #2;
    check_reset_outputs("idle20");
    chk_eq("idle_no_strobe", 64'(st_addr.size() + hs_bank.size() + ndone),
           64'd0);

    // Table vectors.
    for (int k = 0; k < 6; k++) begin
      start_job(tbl[k].src, tbl[k].bytes, tbl[k].n, tbl[k].dl,
                tbl[k].rl, tbl[k].cl, acc);
      wait_job(tbl[k].n);
      check_job(tbl[k].src, tbl[k].bytes, tbl[k].n, acc, 1'b1,
                tbl[k].exp_tiles, tbl[k].exp_last, tbl[k].exp_bank);
      if (k == 0 && st_cyc.size() > 1 && cd_cyc.size() > 0)
        chk_eq("load_overlaps_cmp", 64'(st_cyc[1] < cd_cyc[0]), 64'd1);
      if (k == 1 && st_cyc.size() > 2 && cd_cyc.size() > 0)
        chk_eq("third_load_waits", 64'(st_cyc[2] > cd_cyc[0]), 64'd1);
    end

    // Zero-tile job.
    start_job(32'h9000, 32'h40, 0, 1, 0, 1, acc);
    repeat (4) @(negedge clk_i);
    #2;
    chk_eq("zero_done_pulses", 64'(ndone), 64'd1);
    chk_eq("zero_done_cycle", 64'(done_cyc), 64'(acc + 1));
    chk_eq("zero_activity", 64'(st_addr.size() + hs_bank.size()), 64'd0);
    chk_eq("zero_never_busy", 64'(any_busy), 64'd0);
    chk_eq("zero_tiles_done", 64'(tiles_done_o), 64'd0);

    // Reset in the middle of a DMA wait, then a fresh job.
    start_job(32'h3000, 32'h80, 4, 8, 0, 5, acc);
    for (int t = 0; t < 50 && st_cyc.size() == 0; t++) begin
      @(negedge clk_i); #2;
    end
    chk_eq("midjob_strobe", 64'(st_cyc.size()), 64'd1);
    job_valid_i = 1'b1;
    job_src_addr_i = 32'h5000;
    repeat (2) @(negedge clk_i);
    #2;
    chk_eq("pending_not_taken", 64'({busy_o, job_ready_o}), 64'b10);
    chk_eq("pending_no_new_dma", 64'(st_cyc.size()), 64'd1);
    job_valid_i = 1'b0;
    rst_ni = 1'b0;
    dma_done_at = -1;
    cmp_done_at = -1;
    wait_cnt = 0;
    #1 check_reset_outputs("midjob_reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    start_job(32'h2000, 32'h40, 1, 3, 0, 4, acc);
    wait_job(1);
    check_job(32'h2000, 32'h40, 1, acc, 1'b1, 1, 32'h2000, 1'b0);

    // Random jobs with a jittery DMA ready.
    rand_rdy = 1'b1;
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 6);
      src = $urandom;
      bytes = ($urandom_range(0, 3) == 0) ? $urandom
                                          : 32'($urandom_range(1, 256));
      start_job(src, bytes, n, $urandom_range(1, 5), $urandom_range(0, 3),
                $urandom_range(1, 12), acc);
      wait_job(n);
      check_job(src, bytes, n, acc, 1'b0, n,
                src + 32'(n - 1) * bytes, 1'((n - 1) % 2));
    end
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
